// File: rtl/data_ram_slave.sv
// data_ram_slave
// Responder end of the CPU data-memory bus. Serves single-cycle loads and
// stores to a word-organised on-chip RAM with byte-lane writes, plus a small
// memory-mapped timer block (free-running counter, compare register, sticky
// match flag and interrupt output).
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   ce_i         bus access valid this cycle
//   we_i         1 = store, 0 = load
//   addr_i       byte address (bits [1:0] ignored)
//   sel_i        byte-lane enables for stores
//   data_i       store data
//   data_o       load data, combinational from addr_i, 0 when not loading
//   timer_int_o  registered timer interrupt
//
// Timer register window at IO_BASE, addr_i[3:2]:
//   0 COUNT (RW), 1 COMPARE (RW), 2 CTRL (bit0 count en, bit1 int en),
//   3 STATUS (bit0 sticky match, write 1 on byte-0 lane to clear)
module data_ram_slave #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] IO_BASE    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        timer_int_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    // Replace only the byte lanes enabled in sel, keep the rest of old_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                result[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                result[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return result;
    endfunction

    logic [31:0]           mem_r [0:DEPTH-1];
    logic [31:0]           count_r;
    logic [31:0]           compare_r;
    logic [1:0]            ctrl_r;
    logic                  status_r;
    logic                  timer_int_r;

    logic                  ram_hit_s;
    logic                  io_hit_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [1:0]            reg_sel_s;
    logic                  io_store_s;
    logic                  wr_count_s;
    logic                  wr_compare_s;
    logic                  wr_ctrl_s;
    logic                  wr_status_s;
    logic                  match_s;
    logic [31:0]           count_nxt_s;
    logic [31:0]           compare_nxt_s;
    logic [1:0]            ctrl_nxt_s;
    logic                  status_nxt_s;
    logic [31:0]           rd_data_s;
    logic                  unused_s;

    assign ram_hit_s  = ((addr_i >> (DEPTH_LOG2 + 32'd2)) == 32'd0);
    assign io_hit_s   = (addr_i[31:4] == IO_BASE[31:4]);
    assign ram_idx_s  = addr_i[DEPTH_LOG2+1:2];
    assign reg_sel_s  = addr_i[3:2];
    assign io_store_s = ce_i & we_i & io_hit_s;
    // Compare uses the registered COMPARE, so a same-cycle COMPARE store
    // only affects the next cycle's match check.
    assign match_s    = ctrl_r[0] & (count_r == compare_r);
    assign unused_s   = ^addr_i[1:0];

    // Decode which timer register a store targets this cycle.
    always_comb begin
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_ctrl_s    = 1'b0;
        wr_status_s  = 1'b0;
        if (io_store_s) begin
            case (reg_sel_s)
                2'd0:    wr_count_s   = 1'b1;
                2'd1:    wr_compare_s = 1'b1;
                2'd2:    wr_ctrl_s    = 1'b1;
                2'd3:    wr_status_s  = 1'b1;
                default: wr_count_s   = 1'b0;
            endcase
        end else begin
            wr_count_s = 1'b0;
        end
    end

    // Timer next-state: a COUNT store beats the increment; a new match beats
    // a STATUS clear.
    always_comb begin
        count_nxt_s   = count_r;
        compare_nxt_s = compare_r;
        ctrl_nxt_s    = ctrl_r;
        status_nxt_s  = status_r;
        if (wr_count_s) begin
            count_nxt_s = merge_lanes(count_r, data_i, sel_i);
        end else if (ctrl_r[0]) begin
            count_nxt_s = count_r + 32'd1;
        end else begin
            count_nxt_s = count_r;
        end
        if (wr_compare_s) begin
            compare_nxt_s = merge_lanes(compare_r, data_i, sel_i);
        end else begin
            compare_nxt_s = compare_r;
        end
        // Only byte lane 0 carries implemented CTRL bits.
        if (wr_ctrl_s && sel_i[0]) begin
            ctrl_nxt_s = data_i[1:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        if (match_s) begin
            status_nxt_s = 1'b1;
        end else if (wr_status_s && sel_i[0] && data_i[0]) begin
            status_nxt_s = 1'b0;
        end else begin
            status_nxt_s = status_r;
        end
    end

    // Timer registers and interrupt; reset discards any in-flight IO store.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 32'd0;
            compare_r   <= 32'd0;
            ctrl_r      <= 2'd0;
            status_r    <= 1'b0;
            timer_int_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            compare_r   <= compare_nxt_s;
            ctrl_r      <= ctrl_nxt_s;
            status_r    <= status_nxt_s;
            timer_int_r <= status_r & ctrl_r[1];
        end
    end

    // RAM byte-lane writes; contents are never reset.
    always_ff @(posedge clk) begin
        if (ce_i && we_i && ram_hit_s) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_i[k]) begin
                    mem_r[ram_idx_s][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    // Load data mux: full word, sel_i ignored, zero unless a valid load.
    always_comb begin
        rd_data_s = 32'd0;
        if (rst || !ce_i || we_i) begin
            rd_data_s = 32'd0;
        end else if (ram_hit_s) begin
            rd_data_s = mem_r[ram_idx_s];
        end else if (io_hit_s) begin
            case (reg_sel_s)
                2'd0:    rd_data_s = count_r;
                2'd1:    rd_data_s = compare_r;
                2'd2:    rd_data_s = {30'd0, ctrl_r};
                2'd3:    rd_data_s = {31'd0, status_r};
                default: rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign data_o      = rd_data_s;
    assign timer_int_o = timer_int_r;

endmodule

// File: tb/tb_data_ram_slave.sv
// tb_data_ram_slave
// Directed bench for data_ram_slave: RAM byte-lane stores and loads, decode of
// unmapped addresses, timer register access, match/interrupt timing, counter
// wrap and store priority, and mid-operation reset.
module tb_data_ram_slave;

    localparam logic [31:0] COUNT_A   = 32'h1000_0000;
    localparam logic [31:0] COMPARE_A = 32'h1000_0004;
    localparam logic [31:0] CTRL_A    = 32'h1000_0008;
    localparam logic [31:0] STATUS_A  = 32'h1000_000C;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timer_int;

    int checks;
    int errors;

    data_ram_slave dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .we_i        (we),
        .addr_i      (addr),
        .sel_i       (sel),
        .data_i      (wdata),
        .data_o      (rdata),
        .timer_int_o (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        tick();
        ce = 1'b0; we = 1'b0; wdata = 32'd0; sel = 4'd0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp);
        ce = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
        tick();
        tick();
        // Reset state
        check("rst_int", {31'd0, timer_int}, 32'd0);
        load_check("rst_data", COUNT_A, 32'd0);
        rst = 1'b0;
        load_check("rst_count", COUNT_A, 32'd0);
        load_check("rst_compare", COMPARE_A, 32'd0);
        load_check("rst_ctrl", CTRL_A, 32'd0);
        load_check("rst_status", STATUS_A, 32'd0);

        // RAM full word and byte lanes
        store(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        load_check("ram_word", 32'h0000_0010, 32'hDEAD_BEEF);
        store(32'h0000_0010, 32'h0000_00AA, 4'b0001);
        load_check("ram_lane0", 32'h0000_0010, 32'hDEAD_BEAA);
        store(32'h0000_0010, 32'h1100_0000, 4'b1000);
        load_check("ram_lane3", 32'h0000_0010, 32'h11AD_BEAA);
        // Low address bits ignored
        load_check("ram_addr_lsb", 32'h0000_0013, 32'h11AD_BEAA);

        // data_o gating
        ce = 1'b0; addr = 32'h0000_0010; #1;
        check("ce_low_zero", rdata, 32'd0);
        ce = 1'b1; we = 1'b1; sel = 4'd0; #1;
        check("we_high_zero", rdata, 32'd0);
        ce = 1'b0; we = 1'b0;

        // Unmapped accesses
        load_check("unmapped_load", 32'h2000_0000, 32'd0);
        for (int k = 0; k < 4; k++) begin
            store(32'(4 * k), 32'hA0A0_0000 + 32'(k), 4'hF);
        end
        store(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        store(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        store(32'h1000_0010, 32'hFFFF_FFFF, 4'hF);
        for (int k = 0; k < 4; k++) begin
            load_check("ram_unchanged", 32'(4 * k), 32'hA0A0_0000 + 32'(k));
        end

        // Register lanes and CTRL read-zero bits
        store(CTRL_A, 32'hFFFF_FFFC, 4'hF);
        load_check("ctrl_hi_zero", CTRL_A, 32'd0);
        store(COMPARE_A, 32'h1234_5678, 4'hF);
        store(COMPARE_A, 32'h0000_AB00, 4'b0010);
        load_check("compare_lane1", COMPARE_A, 32'h1234_AB78);

        // Match and interrupt timing
        store(COMPARE_A, 32'd5, 4'hF);
        store(COUNT_A, 32'd0, 4'hF);
        store(CTRL_A, 32'd3, 4'hF);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) load_check("count_start", COUNT_A, 32'd0);
            load_check("status_rise", STATUS_A, (i >= 6) ? 32'd1 : 32'd0);
            check("int_rise", {31'd0, timer_int}, (i >= 7) ? 32'd1 : 32'd0);
            tick();
        end
        store(STATUS_A, 32'd1, 4'b0001);
        load_check("status_clear", STATUS_A, 32'd0);
        check("int_lag", {31'd0, timer_int}, 32'd1);
        tick();
        check("int_clear", {31'd0, timer_int}, 32'd0);
        load_check("count_run", COUNT_A, 32'd11);

        // Counter wrap and store priority over increment
        store(CTRL_A, 32'd1, 4'hF);
        store(COUNT_A, 32'hFFFF_FFFE, 4'hF);
        load_check("wrap_fe", COUNT_A, 32'hFFFF_FFFE);
        tick();
        load_check("wrap_ff", COUNT_A, 32'hFFFF_FFFF);
        tick();
        load_check("wrap_0", COUNT_A, 32'd0);
        tick();
        load_check("wrap_1", COUNT_A, 32'd1);
        store(COUNT_A, 32'h0000_0100, 4'hF);
        load_check("store_wins", COUNT_A, 32'h0000_0100);
        tick();
        load_check("inc_after", COUNT_A, 32'h0000_0101);

        // Match set beats STATUS clear in the same cycle
        store(CTRL_A, 32'd0, 4'hF);
        store(COUNT_A, 32'd5, 4'hF);
        store(CTRL_A, 32'd1, 4'hF);
        load_check("status_pre", STATUS_A, 32'd0);
        tick();
        load_check("status_set", STATUS_A, 32'd1);
        store(COUNT_A, 32'd5, 4'hF);
        store(STATUS_A, 32'd1, 4'b0001);
        load_check("set_wins", STATUS_A, 32'd1);
        store(STATUS_A, 32'd1, 4'b0001);
        load_check("status_clr2", STATUS_A, 32'd0);
        check("int_disabled", {31'd0, timer_int}, 32'd0);

        // Reset mid-count with STATUS set and an IO store in flight
        store(CTRL_A, 32'd3, 4'hF);
        store(COUNT_A, 32'd4, 4'hF);
        tick();
        tick();
        tick();
        load_check("pre_rst_status", STATUS_A, 32'd1);
        check("pre_rst_int", {31'd0, timer_int}, 32'd1);
        rst = 1'b1;
        ce = 1'b1; we = 1'b1; addr = COMPARE_A; wdata = 32'h0000_0077; sel = 4'hF;
        tick();
        ce = 1'b0; we = 1'b0; sel = 4'd0; wdata = 32'd0;
        check("mid_rst_int", {31'd0, timer_int}, 32'd0);
        load_check("mid_rst_data", COUNT_A, 32'd0);
        rst = 1'b0;
        load_check("post_rst_count", COUNT_A, 32'd0);
        load_check("post_rst_status", STATUS_A, 32'd0);
        load_check("post_rst_compare", COMPARE_A, 32'd0);
        load_check("post_rst_ctrl", CTRL_A, 32'd0);
        tick();
        load_check("post_rst_hold", COUNT_A, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
